// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared defaults and lane state encoding for the demux_stream
//                stream demultiplexer and its per-lane buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Default geometry of the demultiplexer.
    localparam int WIDTH_DEF   = 8;
    localparam int SEL_W_DEF   = 3;
    localparam int NUM_OUT_DEF = 8;

    // Width of the optional dropped-word counter.
    localparam int DROP_CNT_W  = 16;

    // One-entry lane buffer occupancy.
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_lane.sv
`default_nettype none
// ============================================================================
//  Module      : demux_lane
//  Description : One-entry output buffer with valid/ready handshake. A load
//                into a full lane that is draining in the same cycle replaces
//                the word without a bubble.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - store i_data this cycle (already accepted)
//                i_data        - word to store
//                i_ready       - consumer takes the held word
//                o_valid       - lane holds a word
//                o_data        - held word (changes only on load or reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    lane_state_t        r_state;
    logic [WIDTH-1:0]   r_data;

    // The top only raises i_load when the lane can take the word, so a load
    // on a full lane always coincides with the old word draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LANE_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                LANE_EMPTY: begin
                    if (i_load) begin
                        r_state <= LANE_FULL;
                        r_data  <= i_data;
                    end
                end
                LANE_FULL: begin
                    if (i_load) begin
                        r_data  <= i_data;
                    end else if (i_ready) begin
                        r_state <= LANE_EMPTY;
                    end
                end
            endcase
        end
    end

    assign o_valid = (r_state == LANE_FULL);
    assign o_data  = r_data;

endmodule : demux_lane
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_stream
//  Description : Registered 1-to-NUM_OUT stream demultiplexer. Each accepted
//                input word is routed to lane in_sel; every lane has its own
//                one-entry buffer, so a stalled lane only blocks words aimed
//                at it. Words with in_sel >= NUM_OUT are accepted, dropped
//                and flagged on err_sel for one cycle.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - input handshake (in_ready is comb.)
//                in_data, in_sel     - input word and destination lane
//                out_valid/out_ready - per-lane output handshake
//                out_data            - lane i at [i*WIDTH +: WIDTH]
//                err_sel             - pulse: word with bad select dropped
//                drop_cnt, lane_busy - optional statistics (DEMUX_STATS_EN)
//  Options     : DEMUX_STATS_EN adds drop_cnt (saturating count of err_sel
//                pulses) and lane_busy (registered per-lane stall flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic                     err_sel
`ifdef DEMUX_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    output logic [NUM_OUT-1:0]       lane_busy
`endif
);

    logic               w_sel_ok;
    logic               w_sel_busy;
    logic               w_accept;
    logic [NUM_OUT-1:0] w_load;
    logic               r_err_sel;

    assign w_sel_ok = (int'(in_sel) < NUM_OUT);

    // A selected lane blocks the input only if it is full and not draining.
    // An out-of-range select matches no lane, so it is never blocked.
    always_comb begin
        w_sel_busy = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_sel_busy = out_valid[i] & ~out_ready[i];
            end
        end
    end

    assign in_ready = ~w_sel_busy;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_load[i] = w_accept;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
            demux_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[gi]),
                .i_data  (in_data),
                .i_ready (out_ready[gi]),
                .o_valid (out_valid[gi]),
                .o_data  (out_data[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sel <= 1'b0;
        end else begin
            r_err_sel <= w_accept & ~w_sel_ok;
        end
    end

    assign err_sel = r_err_sel;

`ifdef DEMUX_STATS_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [NUM_OUT-1:0]    r_lane_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt  <= '0;
            r_lane_busy <= '0;
        end else begin
            if (r_err_sel && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            r_lane_busy <= out_valid & ~out_ready;
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign lane_busy = r_lane_busy;
`endif

endmodule : demux_stream
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_stream
//  Description : Self-checking bench for demux_stream. An 8-lane instance is
//                driven by directed and random vectors; accepted words are
//                pushed into per-lane expected queues by the driver and a
//                negedge monitor pops and compares them. A 5-lane instance
//                exercises the out-of-range select path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_stream;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int NB = 5;
    localparam int SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main 8-lane instance ----------------
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic [SW-1:0]     in_sel = '0;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready = '0;
    logic [N*W-1:0]    out_data;
    logic              err_sel;
`ifdef DEMUX_STATS_EN
    logic [15:0]       drop_cnt;
    logic [N-1:0]      lane_busy;
`endif

    demux_stream #(.WIDTH(W), .NUM_OUT(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel)
`ifdef DEMUX_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .lane_busy (lane_busy)
`endif
    );

    // ---------------- 5-lane instance (invalid selects) ----------------
    logic              b_rst = 1'b1;
    logic              b_in_valid = 1'b0;
    logic              b_in_ready;
    logic [W-1:0]      b_in_data = '0;
    logic [SW-1:0]     b_in_sel = '0;
    logic [NB-1:0]     b_out_valid;
    logic [NB-1:0]     b_out_ready = '0;
    logic [NB*W-1:0]   b_out_data;
    logic              b_err_sel;
`ifdef DEMUX_STATS_EN
    logic [15:0]       b_drop_cnt;
    logic [NB-1:0]     b_lane_busy;
`endif

    demux_stream #(.WIDTH(W), .NUM_OUT(NB), .SEL_W(SW)) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .err_sel   (b_err_sel)
`ifdef DEMUX_STATS_EN
        ,
        .drop_cnt  (b_drop_cnt),
        .lane_busy (b_lane_busy)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    typedef logic [W-1:0] word_q_t[$];
    word_q_t       exp_q [N];
    logic [N-1:0]  m_full  = '0;   // lanes holding a word after the last edge
    logic [N-1:0]  m_zero  = '1;   // lanes whose data must read 0 (post-reset)
    logic [N-1:0]  m_busy  = '0;
    logic          mon_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge. Accepted words
    // are queued as expected lane contents for the monitor.
    task automatic drive(input logic r, input logic v, input logic [SW-1:0] s,
                         input logic [W-1:0] d, input logic [N-1:0] rdy);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        if (!r && v && (!m_full[s] || rdy[s])) begin
            exp_q[s].push_back(d);
        end
    endtask

    // Monitor: compare against the model, then advance the model across
    // the coming rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", in_ready, !m_full[in_sel] || out_ready[in_sel]);
            chk("out_valid", out_valid, m_full);
            chk("err_sel", err_sel, 1'b0);
`ifdef DEMUX_STATS_EN
            chk("lane_busy", lane_busy, m_busy);
            chk("drop_cnt", drop_cnt, 16'd0);
`endif
            for (int i = 0; i < N; i++) begin
                if (m_full[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("lane_queue_empty", 1, 0);
                    end else begin
                        chk($sformatf("lane%0d_data", i), out_data[i*W +: W], exp_q[i][0]);
                    end
                end else if (m_zero[i]) begin
                    chk($sformatf("lane%0d_reset_data", i), out_data[i*W +: W], '0);
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            m_full = '0;
            m_zero = '1;
            m_busy = '0;
        end else begin
            m_busy = m_full & ~out_ready;
            for (int i = 0; i < N; i++) begin
                if (m_full[i] && out_ready[i] && exp_q[i].size() != 0) begin
                    void'(exp_q[i].pop_front());
                end
                m_full[i] = (exp_q[i].size() != 0);
                if (m_full[i]) m_zero[i] = 1'b0;
            end
        end
    end

    initial begin
        // Reset with all consumers stalled.
        drive(1, 0, 0, 8'h00, 8'h00);
        mon_en = 1'b1;
        drive(1, 0, 0, 8'h00, 8'h00);

        // Single word to lane 3, then it sits stalled.
        drive(0, 1, 3, 8'hA5, 8'h00);
        drive(0, 1, 3, 8'h11, 8'h00);   // lane 3 full: refused
        drive(0, 0, 2, 8'h00, 8'h00);   // lane 2 empty: ready

        // Drain and reload lane 3 in the same cycle.
        drive(0, 1, 3, 8'h3C, 8'h08);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'hFF);

        // One word per lane on consecutive cycles, all consumers ready.
        for (int i = 0; i < N; i++) drive(0, 1, SW'(i), W'(i), 8'hFF);
        drive(0, 0, 0, 8'h00, 8'hFF);

        // Fill lanes 1 and 6, reset with a word on offer.
        drive(0, 1, 1, 8'h61, 8'h00);
        drive(0, 1, 6, 8'h66, 8'h00);
        drive(1, 1, 2, 8'h77, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            drive(0, 1'($urandom_range(0, 1)), SW'($urandom_range(0, N-1)),
                  W'($urandom), N'($urandom & $urandom));
        end
        drive(0, 0, 0, 8'h00, 8'hFF);
        drive(0, 0, 0, 8'h00, 8'hFF);
        mon_en = 1'b0;

        // 5-lane instance: out-of-range selects.
        @(posedge clk); #1;
        b_rst = 1'b0;
        b_in_valid = 1'b1; b_in_sel = 3'd4; b_in_data = 8'h44;   // fill lane 4
        @(negedge clk);
        chk("b_in_ready_lane4_empty", b_in_ready, 1'b1);
        @(posedge clk); #1;
        b_in_sel = 3'd6; b_in_data = 8'hFF;
        @(negedge clk);
        chk("b_in_ready_sel6", b_in_ready, 1'b1);
        chk("b_out_valid_lane4", b_out_valid, 5'b10000);
        chk("b_err_before", b_err_sel, 1'b0);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_err_pulse", b_err_sel, 1'b1);
        chk("b_out_valid_unchanged", b_out_valid, 5'b10000);
        chk("b_lane4_data", b_out_data[4*W +: W], 8'h44);
`ifdef DEMUX_STATS_EN
        chk("b_drop_cnt_before", b_drop_cnt, 16'd0);
`endif
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_sel = 3'd5; b_in_data = 8'h55;
        @(negedge clk);
        chk("b_err_one_cycle", b_err_sel, 1'b0);
        chk("b_in_ready_sel5", b_in_ready, 1'b1);
`ifdef DEMUX_STATS_EN
        chk("b_drop_cnt_one", b_drop_cnt, 16'd1);
`endif
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_err_pulse2", b_err_sel, 1'b1);
        chk("b_out_valid_still", b_out_valid, 5'b10000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_err_clear", b_err_sel, 1'b0);
`ifdef DEMUX_STATS_EN
        chk("b_drop_cnt_two", b_drop_cnt, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_demux_stream
`default_nettype wire
